// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - 3-stage pipelined fp32 multiplier with valid/ready; FMUL_ROUND_NEAREST_EN selects round-to-nearest-even
module fmul_pipe #(
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_prod,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // Truncation only ever looks at product bits 47..23, so the low bits are
    // not kept in that build; nearest-even needs the full product for sticky.
`ifdef FMUL_ROUND_NEAREST_EN
    localparam int PLSB = 0;
`else
    localparam int PLSB = 23;
`endif

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Global stall: every stage moves when the output register can be refilled.
    logic adv;

    // Stage 1 (unpack) registers
    logic              s1_valid;
    logic              s1_sign;
    logic signed [9:0] s1_esum;
    logic [23:0]       s1_ma;
    logic [23:0]       s1_mb;
    logic              s1_nan;
    logic              s1_inf;
    logic              s1_zero;
    logic [TAG_W-1:0]  s1_tag;

    // Stage 2 (multiply) registers
    logic              s2_valid;
    logic              s2_sign;
    logic signed [9:0] s2_esum;
    logic [47:PLSB]    s2_prod;
    logic              s2_nan;
    logic              s2_inf;
    logic              s2_zero;
    logic [TAG_W-1:0]  s2_tag;

    // Unpack combinational signals
    logic              a_zero;
    logic              b_zero;
    logic              a_inf;
    logic              b_inf;
    logic              a_nan;
    logic              b_nan;
    logic              u_nan;
    logic              u_inf;
    logic              u_zero;
    logic signed [9:0] u_esum;

    // Normalise/pack combinational signals
    logic [22:0]       frac;
    logic              round_up;
    logic [23:0]       frac_r;
    logic              norm_inc;
    logic signed [9:0] e_fin;
    logic [31:0]       packed_res;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~rst;
    assign busy     = s1_valid | s2_valid | out_valid;

    // Classify operands and resolve the special-value result class up front.
    always_comb begin
        a_zero = (in_a[30:23] == 8'h00);
        b_zero = (in_b[30:23] == 8'h00);
        a_inf  = (in_a[30:23] == 8'hFF) && (in_a[22:0] == 23'h0);
        b_inf  = (in_b[30:23] == 8'hFF) && (in_b[22:0] == 23'h0);
        a_nan  = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'h0);
        b_nan  = (in_b[30:23] == 8'hFF) && (in_b[22:0] != 23'h0);
        u_nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        u_inf  = (a_inf | b_inf) & ~u_nan;
        u_zero = (a_zero | b_zero) & ~u_nan & ~u_inf;
        u_esum = {2'b00, in_a[30:23]} + {2'b00, in_b[30:23]} - 10'd127;
    end

    // Stage 1 register: capture unpacked operands; bubbles enter as invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_sign  <= in_a[31] ^ in_b[31];
            s1_esum  <= u_esum;
            s1_ma    <= {1'b1, in_a[22:0]};
            s1_mb    <= {1'b1, in_b[22:0]};
            s1_nan   <= u_nan;
            s1_inf   <= u_inf;
            s1_zero  <= u_zero;
            s1_tag   <= in_tag;
        end
    end

    // Stage 2 register: 24x24 mantissa product, flags and tag ride along.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_esum  <= s1_esum;
            s2_prod  <= (48 - PLSB)'(({24'h0, s1_ma} * {24'h0, s1_mb}) >> PLSB);
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
            s2_zero  <= s1_zero;
            s2_tag   <= s1_tag;
        end
    end

    // Normalise so the leading one sits above frac, round, then range-check.
    always_comb begin
        norm_inc = s2_prod[47];
`ifdef FMUL_ROUND_NEAREST_EN
        begin : rne
            logic [46:0] norm;
            logic        guard;
            logic        rnd;
            logic        sticky;
            norm     = s2_prod[47] ? s2_prod[46:0] : {s2_prod[45:0], 1'b0};
            frac     = norm[46:24];
            guard    = norm[23];
            rnd      = norm[22];
            sticky   = |norm[21:0];
            round_up = guard & (rnd | sticky | frac[0]);
        end
`else
        frac     = s2_prod[47] ? s2_prod[46:24] : s2_prod[45:23];
        round_up = 1'b0;
`endif
        frac_r = {1'b0, frac} + {23'h0, round_up};
        e_fin  = s2_esum + {9'h0, norm_inc} + {9'h0, frac_r[23]};

        if (s2_nan) begin
            packed_res = QNAN;
        end else if (s2_inf) begin
            packed_res = {s2_sign, 8'hFF, 23'h0};
        end else if (s2_zero) begin
            packed_res = {s2_sign, 31'h0};
        end else if (e_fin >= 10'sd255) begin
            packed_res = {s2_sign, 8'hFF, 23'h0};
        end else if (e_fin <= 10'sd0) begin
            packed_res = {s2_sign, 31'h0};
        end else begin
            packed_res = {s2_sign, e_fin[7:0], frac_r[22:0]};
        end
    end

    // Output register: only a valid operation overwrites prod/tag, so they
    // hold their last value across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_prod  <= 32'h0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_prod <= packed_res;
                out_tag  <= s2_tag;
            end
        end
    end

endmodule
